// File: rtl/vend_sequencer.sv
// vend_sequencer: transaction controller for the can vending machine.
//
// Accumulates coin credit against a fixed PRICE, runs the product dispenser
// request/acknowledge handshake, then pays change one coin at a time (dimes
// first, then a nickel) through the change dispenser handshake. A refund
// request pays the whole credit back through the same change path. A missing
// acknowledge within ACK_TIMEOUT waiting cycles parks the block in a sticky
// fault state that only RST leaves.
//
// Ports:
//   Clk        system clock, rising edge
//   RST        synchronous active-high reset
//   N, D, Q    nickel / dime / quarter inserted (single-cycle pulses)
//   CANCEL     refund request (level)
//   VEND_REQ   product dispense request (level)
//   VEND_ACK   product dispensed (pulse)
//   CHG_N      request one nickel of change (level)
//   CHG_D      request one dime of change (level)
//   CHG_ACK    one change coin ejected (pulse)
//   COIN_RET   coin rejected and returned (pulse)
//   VENDED     transaction finished with a can (pulse)
//   BUSY       high in every state except idle
//   FAULT      handshake timeout (sticky)
//   CREDIT     current credit / remaining change in cents
module vend_sequencer #(
    parameter int unsigned PRICE       = 30,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       Clk,
    input  logic       RST,
    input  logic       N,
    input  logic       D,
    input  logic       Q,
    input  logic       CANCEL,
    output logic       VEND_REQ,
    input  logic       VEND_ACK,
    output logic       CHG_N,
    output logic       CHG_D,
    input  logic       CHG_ACK,
    output logic       COIN_RET,
    output logic       VENDED,
    output logic       BUSY,
    output logic       FAULT,
    output logic [6:0] CREDIT
);

    localparam logic [6:0] PriceC   = 7'(PRICE);
    localparam logic [7:0] WaitLast = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StVend,
        StChange,
        StDone,
        StFault
    } state_e;

    state_e      state_q, state_d;
    // Credit while collecting; remaining change once the can is paid for.
    logic [6:0]  credit_q, credit_d;
    logic [7:0]  wait_q, wait_d;
    // Remembers that this transaction went through the vend handshake.
    logic        went_vend_q, went_vend_d;
    logic        coin_ret_d;

    logic [1:0]  coin_cnt;
    logic [6:0]  coin_val;

    always_comb begin
        coin_cnt = {1'b0, N} + {1'b0, D} + {1'b0, Q};
        coin_val = 7'd0;
        if (N) begin
            coin_val = 7'd5;
        end else if (D) begin
            coin_val = 7'd10;
        end else if (Q) begin
            coin_val = 7'd25;
        end
    end

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        wait_d      = wait_q;
        went_vend_d = went_vend_q;
        coin_ret_d  = 1'b0;

        case (state_q)
            StIdle: begin
                went_vend_d = 1'b0;
                wait_d      = 8'd0;
                if (coin_cnt > 2'd1) begin
                    coin_ret_d = 1'b1;
                end else if (coin_cnt == 2'd1) begin
                    credit_d = credit_q + coin_val;
                end
                // Refund wins over the vend threshold, covering any coin
                // credited in the same cycle.
                if (CANCEL && (credit_d != 7'd0)) begin
                    state_d = StChange;
                end else if (credit_d >= PriceC) begin
                    state_d = StVend;
                end
            end

            StVend: begin
                if (VEND_ACK) begin
                    credit_d    = credit_q - PriceC;
                    went_vend_d = 1'b1;
                    wait_d      = 8'd0;
                    state_d     = (credit_d != 7'd0) ? StChange : StDone;
                end else if (wait_q == WaitLast) begin
                    state_d = StFault;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            StChange: begin
                if (CHG_ACK) begin
                    credit_d = credit_q - ((credit_q >= 7'd10) ? 7'd10 : 7'd5);
                    wait_d   = 8'd0;
                    if (credit_d == 7'd0) begin
                        state_d = StDone;
                    end
                end else if (wait_q == WaitLast) begin
                    state_d = StFault;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            StDone: begin
                credit_d = 7'd0;
                state_d  = StIdle;
            end

            StFault: begin
                state_d = StFault;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Coins are only accepted in idle; anything else goes straight back.
        if ((state_q != StIdle) && (coin_cnt != 2'd0)) begin
            coin_ret_d = 1'b1;
        end
    end

    // Outputs are registered from the next-state values so every output
    // changes on the same edge as the state it describes.
    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q     <= StIdle;
            credit_q    <= 7'd0;
            wait_q      <= 8'd0;
            went_vend_q <= 1'b0;
            VEND_REQ    <= 1'b0;
            CHG_N       <= 1'b0;
            CHG_D       <= 1'b0;
            COIN_RET    <= 1'b0;
            VENDED      <= 1'b0;
            BUSY        <= 1'b0;
            FAULT       <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            wait_q      <= wait_d;
            went_vend_q <= went_vend_d;
            VEND_REQ    <= (state_d == StVend);
            CHG_D       <= (state_d == StChange) && (credit_d >= 7'd10);
            CHG_N       <= (state_d == StChange) && (credit_d < 7'd10);
            COIN_RET    <= coin_ret_d;
            VENDED      <= (state_d == StDone) && went_vend_d;
            BUSY        <= (state_d != StIdle);
            FAULT       <= (state_d == StFault);
        end
    end

    assign CREDIT = credit_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer. Stimulus tasks compute expected
// events from the pricing rules (running credit sum, greedy dime/nickel
// change) and queue them tagged with the clock edge they must appear on; an
// independent monitor turns DUT output activity into events and matches them.
module tb_vend_sequencer;

    localparam int PRICE = 30;
    localparam int TMO   = 8;

    localparam int KCredit = 0;
    localparam int KVreq   = 1;
    localparam int KChg    = 2;
    localparam int KRet    = 3;
    localparam int KDone   = 4;
    localparam int KFault  = 5;

    logic       Clk = 1'b0;
    logic       RST = 1'b1;
    logic       N = 1'b0, D = 1'b0, Q = 1'b0, CANCEL = 1'b0;
    logic       VEND_ACK = 1'b0, CHG_ACK = 1'b0;
    logic       VEND_REQ, CHG_N, CHG_D, COIN_RET, VENDED, BUSY, FAULT;
    logic [6:0] CREDIT;

    vend_sequencer #(
        .PRICE       (PRICE),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .Clk      (Clk),
        .RST      (RST),
        .N        (N),
        .D        (D),
        .Q        (Q),
        .CANCEL   (CANCEL),
        .VEND_REQ (VEND_REQ),
        .VEND_ACK (VEND_ACK),
        .CHG_N    (CHG_N),
        .CHG_D    (CHG_D),
        .CHG_ACK  (CHG_ACK),
        .COIN_RET (COIN_RET),
        .VENDED   (VENDED),
        .BUSY     (BUSY),
        .FAULT    (FAULT),
        .CREDIT   (CREDIT)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  m_credit = 0;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic expect_ev(input int kind, input int k, input int v);
        exp_q.push_back('{kind: kind, cyc: k, val: v});
    endtask

    task automatic observe(input int kind, input int k, input int v, input string name);
        int idx = -1;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i].kind == kind) idx = i;
        n_checks++;
        if (idx < 0) begin
            $display("FAIL %s: unexpected event at cycle %0d value %0d", name, k, v);
        end else begin
            if (exp_q[idx].cyc == k && exp_q[idx].val == v) n_pass++;
            else $display("FAIL %s: got cycle %0d value %0d, want cycle %0d value %0d",
                          name, k, v, exp_q[idx].cyc, exp_q[idx].val);
            exp_q.delete(idx);
        end
    endtask

    // Drive one edge's worth of inputs; called and returns at a falling edge.
    task automatic drive(input logic n, d, q, c, va, ca);
        N = n; D = d; Q = q; CANCEL = c; VEND_ACK = va; CHG_ACK = ca;
        @(negedge Clk);
        N = 0; D = 0; Q = 0; CANCEL = 0; VEND_ACK = 0; CHG_ACK = 0;
    endtask

    task automatic idle(input int n, input bit strays);
        for (int i = 0; i < n; i++) begin
            logic va, ca;
            va = strays && ($urandom_range(0, 4) == 0);
            ca = strays && ($urandom_range(0, 4) == 0);
            drive(0, 0, 0, 0, va, ca);
        end
    endtask

    task automatic stray_coin();
        expect_ev(KRet, cyc + 1, 1);
        drive(0, 0, 1, 0, 0, 0);
    endtask

    task automatic coin(input int v, input bit cancel);
        int k = cyc + 1;
        m_credit += v;
        expect_ev(KCredit, k, m_credit);
        if (!cancel && m_credit >= PRICE) expect_ev(KVreq, k, 1);
        drive(v == 5, v == 10, v == 25, cancel, 0, 0);
    endtask

    task automatic bad_coin();
        int p = $urandom_range(0, 3);
        expect_ev(KRet, cyc + 1, 1);
        drive(p != 2, p != 1, p != 0, 0, 0, 0);
    endtask

    task automatic finish_done(input int klast, input bit vended, input bit strays);
        int k = klast + 1;
        expect_ev(KDone, k, vended);
        if (strays && $urandom_range(0, 1) == 1) begin
            expect_ev(KRet, k, 1);
            drive(0, 1, 0, 0, 0, 0);
        end else begin
            drive(0, 0, 0, 0, 0, 0);
        end
        m_credit = 0;
    endtask

    task automatic change_flow(input bit vended, input bit strays);
        int k = cyc;
        while (m_credit > 0) begin
            int c = (m_credit >= 10) ? 10 : 5;
            int dly = $urandom_range(0, 4);
            for (int i = 0; i < dly; i++) begin
                if (strays && $urandom_range(0, 2) == 0) stray_coin();
                else drive(0, 0, 0, 0, 0, 0);
            end
            k = cyc + 1;
            expect_ev(KChg, k, c);
            m_credit -= c;
            expect_ev(KCredit, k, m_credit);
            drive(0, 0, 0, 0, 0, 1);
        end
        finish_done(k, vended, strays);
    endtask

    task automatic vend_flow(input int dly, input bit strays);
        int k;
        for (int i = 0; i < dly; i++) begin
            logic sc, cc;
            sc = strays && ($urandom_range(0, 2) == 0);
            cc = strays && ($urandom_range(0, 2) == 0);
            if (sc) expect_ev(KRet, cyc + 1, 1);
            drive(sc, 0, 0, cc, 0, 0);
        end
        k = cyc + 1;
        m_credit -= PRICE;
        expect_ev(KCredit, k, m_credit);
        drive(0, 0, 0, 0, 1, 0);
        if (m_credit == 0) finish_done(k, 1, strays);
        else change_flow(1, strays);
    endtask

    task automatic cancel_only(input bit strays);
        drive(0, 0, 0, 1, 0, 0);
        if (m_credit > 0) change_flow(0, strays);
    endtask

    task automatic random_txn();
        bit fin = 0;
        while (!fin) begin
            int r;
            idle($urandom_range(0, 2), 1);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                bad_coin();
            end else if (r <= 2) begin
                fin = (m_credit > 0);
                cancel_only(1);
            end else begin
                int  sel = $urandom_range(0, 2);
                int  v   = (sel == 0) ? 5 : ((sel == 1) ? 10 : 25);
                bit  cx  = (r == 3) && (m_credit > 0);
                coin(v, cx);
                if (cx) begin
                    change_flow(0, 1);
                    fin = 1;
                end else if (m_credit >= PRICE) begin
                    vend_flow($urandom_range(0, 5), 1);
                    fin = 1;
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        RST = 1;
        repeat (n) @(negedge Clk);
        RST = 0;
        m_credit = 0;
    endtask

    task automatic check_reset(input string p);
        chk({p, "_credit"}, int'(CREDIT), 0);
        chk({p, "_vend_req"}, int'(VEND_REQ), 0);
        chk({p, "_chg_d"}, int'(CHG_D), 0);
        chk({p, "_chg_n"}, int'(CHG_N), 0);
        chk({p, "_coin_ret"}, int'(COIN_RET), 0);
        chk({p, "_vended"}, int'(VENDED), 0);
        chk({p, "_busy"}, int'(BUSY), 0);
        chk({p, "_fault"}, int'(FAULT), 0);
    endtask

    // Monitor: sample just after each rising edge; inputs still hold the
    // values that edge sampled.
    logic [6:0] p_credit = '0;
    logic       p_vreq = 0, p_chg_d = 0, p_chg_n = 0, p_busy = 0;
    logic       p_vended = 0, p_fault = 0;

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (!RST) begin
                if (COIN_RET) observe(KRet, cyc, 1, "coin_ret");
                if (CHG_ACK && p_chg_d) observe(KChg, cyc, 10, "chg_coin");
                if (CHG_ACK && p_chg_n) observe(KChg, cyc, 5, "chg_coin");
                if (CREDIT != p_credit) observe(KCredit, cyc, int'(CREDIT), "credit");
                if (VEND_REQ && !p_vreq) observe(KVreq, cyc, 1, "vend_req_rise");
                if (p_busy && !BUSY) observe(KDone, cyc, int'(p_vended), "done_vended");
                if (FAULT && !p_fault) observe(KFault, cyc, 1, "fault_rise");
                if (CHG_D || CHG_N) chk("chg_onehot", int'(CHG_D & CHG_N), 0);
            end
            p_credit = CREDIT;
            p_vreq   = VEND_REQ;
            p_chg_d  = CHG_D;
            p_chg_n  = CHG_N;
            p_busy   = BUSY;
            p_vended = VENDED;
            p_fault  = FAULT;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int kv;
        repeat (3) @(negedge Clk);
        RST = 0;
        check_reset("reset");

        // Exact price: quarter, gap, nickel, immediate acknowledge.
        coin(25, 0);
        idle(2, 0);
        coin(5, 0);
        vend_flow(0, 0);

        // Two quarters: 20 cents of change as two dimes.
        coin(25, 0);
        coin(25, 0);
        vend_flow(2, 0);

        // Dime, nickel, cancel: refund with a coin inserted mid-refund.
        coin(10, 0);
        coin(5, 0);
        drive(0, 0, 0, 1, 0, 0);
        stray_coin();
        change_flow(0, 0);

        // Nickel and dime together are rejected.
        expect_ev(KRet, cyc + 1, 1);
        drive(1, 1, 0, 0, 0, 0);
        chk("dual_coin_credit", int'(CREDIT), 0);

        // Coin together with cancel refunds the new total, no vend.
        coin(10, 0);
        coin(25, 1);
        change_flow(0, 0);

        for (int t = 0; t < 40; t++) random_txn();

        // Vend acknowledge never arrives.
        coin(25, 0);
        idle(2, 0);
        kv = cyc + 1;
        expect_ev(KFault, kv + TMO, 1);
        coin(5, 0);
        idle(TMO + 1, 0);
        stray_coin();
        idle(1, 0);
        chk("fault_out", int'(FAULT), 1);
        chk("fault_vend_req", int'(VEND_REQ), 0);
        chk("fault_busy", int'(BUSY), 1);
        chk("fault_credit", int'(CREDIT), PRICE);
        do_reset(1);
        check_reset("after_fault");

        // Reset while a dime of change is outstanding.
        coin(25, 0);
        coin(25, 0);
        expect_ev(KCredit, cyc + 1, 50 - PRICE);
        drive(0, 0, 0, 0, 1, 0);
        idle(2, 0);
        chk("mid_chg_req", int'(CHG_D), 1);
        do_reset(1);
        check_reset("mid_chg_reset");
        coin(25, 0);
        coin(5, 0);
        vend_flow(1, 0);

        idle(4, 0);
        chk("pending_events", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
